relojes_nco: RTL and testbench
==============================

Name: relojes_nco

Overview:
- Parametrised multi-channel clock-enable generator. It is the successor to the fixed single-output PLL clock block.
- Runs in the single PLL-derived master clock domain. Produces NUM_CH independent fractional-rate clock-enable pulses using phase-accumulator NCOs, e.g. 3.5/7/14 MHz CPU/ULA/turbo enables from 28 MHz.
- Rates are reprogrammable at run time with glitch-free switching. A LOCKED-style startup gate holds all outputs quiet after reset.

Parameters:
- NUM_CH, 4, number of independent enable channels (1..8).
- ACC_W, 24, phase accumulator and increment width in bits.
- DEFAULT_INC, 24'h200000, reset increment for every channel. This gives master/8.
- STARTUP_CYC, 16, cycles after reset release before LOCKED rises and the accumulators run (>=1).

Ports:
- CLK_IN1  in  1  master clock; all logic on its rising edge
- RST  in  1  synchronous, active-high reset
- CFG_VALID  in  1  increment write request
- CFG_READY  out  1  write accepted when CFG_VALID && CFG_READY
- CFG_CH  in  $clog2(NUM_CH) (min 1)  target channel
- CFG_INC  in  ACC_W  new increment for CFG_CH
- CE_OUT  out  NUM_CH  one-cycle enable pulses, registered
- PENDING  out  NUM_CH  staged increment not yet applied, per channel
- LOCKED  out  1  startup delay elapsed; channels running

Behaviour:
- Reset (RST high at an edge) sets:
  - acc = 0, active_inc = DEFAULT_INC, staged_inc = 0 for all channels.
  - CE_OUT = 0, PENDING = 0, LOCKED = 0, startup counter = 0.
  - Any staged write is discarded.
  - Reset mid-operation behaves identically; no pulse is emitted in the reset cycle.
- Startup:
  - The counter increments each cycle while LOCKED = 0.
  - LOCKED registers high at the edge where counter == STARTUP_CYC-1, i.e. LOCKED is high in the STARTUP_CYC-th cycle after RST falls. It then stays high until RST.
  - Accumulators are frozen and CE_OUT = 0 while LOCKED = 0.
- NCO, per channel, each edge while LOCKED:
  - sum[ACC_W:0] = acc + active_inc (ACC_W+1 bits, unsigned).
  - acc <= sum[ACC_W-1:0] (wraps modulo 2^ACC_W).
  - CE_OUT[ch] <= sum[ACC_W].
  - Average pulse rate = f_clk * inc / 2^ACC_W. A pulse is never wider than one cycle unless inc >= 2^ACC_W - acc repeatedly; inc = 2^ACC_W-1 may give back-to-back pulses.
- Config handshake:
  - CFG_READY = LOCKED && !PENDING[CFG_CH] (combinational from CFG_CH).
  - CFG_CH >= NUM_CH: CFG_READY = 0; the write is never accepted.
  - On acceptance: staged_inc[CFG_CH] <= CFG_INC, PENDING[CFG_CH] <= 1.
- Apply:
  - A pending channel copies staged_inc into active_inc at the edge where its sum[ACC_W] = 1, i.e. the same edge that registers the CE pulse. PENDING clears at that edge.
  - acc is not cleared, so there is no phase jump and no runt or double pulse.
  - Special case: if active_inc == 0 (the channel never carries), the staged value applies at the edge after acceptance.
- Simultaneous events: an accept and a carry can occur in the same cycle on different channels and are independent. On the same channel an accept cannot coincide with its own apply, because READY is low while pending.

Optional Feature:
- Macro: RELOJES_SQ_OUT_EN.
- Defined:
  - Adds output SQ_OUT[NUM_CH-1:0], reset 0.
  - Each bit toggles at every edge where the corresponding CE_OUT bit is registered high. This gives a ~50% square clock at half the enable rate, usable as a fabric clock-like signal for audio or peripherals.
  - Held while LOCKED = 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package relojes_pkg:
  - ACC_W_DEF.
  - Increment constants for a 28 MHz base, ACC_W = 24: INC_3M5 = 24'h200000, INC_7M = 24'h400000, INC_14M = 24'h800000.
  - INC_OFF = 0.
- Sub-module relojes_nco_ch:
  - One accumulator with active/staged increment, pending flag, carry and apply logic.
  - Instantiated NUM_CH times by generate.
- The top holds the startup counter, READY decode and channel select.

Test Plan:
1. Reset release with default parameters -> LOCKED rises in the 16th cycle. First CE_OUT[0] follows 8 cycles later, then every 8 cycles on all channels; CFG_READY = 0 before LOCKED.
2. Write CH1 INC = 24'h400000 mid-period -> PENDING[1] = 1 and CFG_READY = 0 for CH1 until the next CH1 pulse. Subsequent CH1 period is 4 cycles with no extra or missing pulse; CH0 is undisturbed.
3. INC = 24'h155555 (master/12 approx) -> over 12000 cycles, CE count is 1000 ±1 and every pulse is one cycle wide.
4. Write INC_OFF to CH2, then INC_14M -> CH2 stops pulsing after its next carry. The second write applies the cycle after acceptance, then a pulse appears every 2 cycles.
5. RST asserted for 1 cycle while PENDING[3] = 1 and mid-count -> all outputs 0 next cycle, PENDING cleared, the DEFAULT_INC rate resumes after a new 16-cycle startup.
6. With RELOJES_SQ_OUT_EN and INC_3M5 -> SQ_OUT[0] toggles every 8 cycles (16-cycle period) and is 0 in reset.

Source files
------------

// File: rtl/relojes_pkg.sv
// relojes_pkg: shared widths and 28 MHz-base increment constants for relojes_nco
package relojes_pkg;
  localparam int ACC_W_DEF = 24;
  localparam logic [23:0] INC_3M5 = 24'h200000;
  localparam logic [23:0] INC_7M = 24'h400000;
  localparam logic [23:0] INC_14M = 24'h800000;
  localparam logic [23:0] INC_OFF = 24'h000000;
endpackage

// File: rtl/relojes_nco_ch.sv
// relojes_nco_ch: one NCO enable channel, staged increment applied on its own carry (SQ toggle with RELOJES_SQ_OUT_EN)
module relojes_nco_ch
  import relojes_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(INC_3M5)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
  output logic             ce,
  output logic             pending
`ifdef RELOJES_SQ_OUT_EN
  ,
  output logic             sq
`endif
);
  logic [ACC_W-1:0] acc, act, stg;
  logic [ACC_W:0] sum;
  logic carry, apply;
  always_comb begin
    sum = {1'b0, acc} + {1'b0, act};
    carry = run & sum[ACC_W];
    apply = pending & run & (sum[ACC_W] | ~|act);
  end
  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0;
      act <= DEFAULT_INC;
      stg <= '0;
      pending <= 1'b0;
      ce <= 1'b0;
    end else begin
      ce <= carry;
      acc <= run ? sum[ACC_W-1:0] : acc;
      if (wr) begin
        stg <= wr_inc;
        pending <= 1'b1;
      end else if (apply) begin
        act <= stg;
        pending <= 1'b0;
      end
    end
`ifdef RELOJES_SQ_OUT_EN
  always_ff @(posedge clk)
    if (rst) sq <= 1'b0;
    else sq <= sq ^ carry;
`endif
endmodule

// File: rtl/relojes_nco.sv
// relojes_nco: NUM_CH fractional clock-enable NCOs with startup LOCKED gate and valid/ready rate writes (SQ_OUT with RELOJES_SQ_OUT_EN)
module relojes_nco
  import relojes_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ACC_W = ACC_W_DEF,
  parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(INC_3M5),
  parameter int STARTUP_CYC = 16,
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK_IN1,
  input  logic              RST,
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  input  logic [CHW-1:0]    CFG_CH,
  input  logic [ACC_W-1:0]  CFG_INC,
  output logic [NUM_CH-1:0] CE_OUT,
  output logic [NUM_CH-1:0] PENDING,
`ifdef RELOJES_SQ_OUT_EN
  output logic [NUM_CH-1:0] SQ_OUT,
`endif
  output logic              LOCKED
);
  localparam int CW = STARTUP_CYC > 1 ? $clog2(STARTUP_CYC) : 1;
  localparam int PW = 2 ** CHW;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pend_pad;
  logic accept;
  always_comb begin
    pend_pad = PW'(PENDING);
    CFG_READY = LOCKED && (32'(CFG_CH) < NUM_CH) && !pend_pad[CFG_CH];
    accept = CFG_VALID && CFG_READY;
  end
  always_ff @(posedge CLK_IN1)
    if (RST) begin
      cnt <= '0;
      LOCKED <= 1'b0;
    end else if (!LOCKED) begin
      cnt <= cnt + CW'(1);
      LOCKED <= cnt == CW'(STARTUP_CYC - 1);
    end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    relojes_nco_ch #(
      .ACC_W(ACC_W),
      .DEFAULT_INC(DEFAULT_INC)
    ) u_ch (
      .clk(CLK_IN1),
      .rst(RST),
      .run(LOCKED),
      .wr(accept && CFG_CH == CHW'(c)),
      .wr_inc(CFG_INC),
      .ce(CE_OUT[c]),
      .pending(PENDING[c])
`ifdef RELOJES_SQ_OUT_EN
      ,
      .sq(SQ_OUT[c])
`endif
    );
  end
endmodule

// File: tb/tb_relojes_nco.sv
// tb_relojes_nco: randomized scoreboard bench for relojes_nco against a phase-arithmetic reference model
module tb_relojes_nco;
  import relojes_pkg::*;
  localparam int N = 4;
  localparam longint M = 64'd1 << 24;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, v, ready, locked;
  logic [1:0] ch;
  logic [23:0] inc;
  logic [N-1:0] ce, pend;
`ifdef RELOJES_SQ_OUT_EN
  logic [N-1:0] sq;
`endif
  relojes_nco #(
    .NUM_CH(N),
    .ACC_W(24),
    .DEFAULT_INC(24'h200000),
    .STARTUP_CYC(16)
  ) dut (
    .CLK_IN1(clk),
    .RST(rst),
    .CFG_VALID(v),
    .CFG_READY(ready),
    .CFG_CH(ch),
    .CFG_INC(inc),
    .CE_OUT(ce),
    .PENDING(pend),
`ifdef RELOJES_SQ_OUT_EN
    .SQ_OUT(sq),
`endif
    .LOCKED(locked)
  );
  typedef struct {
    logic [N-1:0] ce;
    logic [N-1:0] pend;
    logic [N-1:0] sq;
    logic lock;
    logic ready;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  longint m_acc[N], m_act[N], m_stg[N];
  bit [N-1:0] m_pend, m_ce, m_sq;
  bit m_lock, m_ok;
  int m_cnt;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic bit m_ready(input int c);
    return m_lock && c < N && !m_pend[c];
  endfunction
  task automatic m_edge(input bit r, input bit vv, input int c, input longint i);
    bit take;
    longint phase;
    take = vv && m_ready(c);
    if (r) begin
      for (int k = 0; k < N; k++) begin
        m_acc[k] = 0;
        m_act[k] = M / 8;
        m_stg[k] = 0;
      end
      m_pend = '0;
      m_ce = '0;
      m_sq = '0;
      m_lock = 0;
      m_cnt = 0;
      m_ok = 1;
      return;
    end
    if (!m_ok) return;
    for (int k = 0; k < N; k++) begin
      if (m_lock) begin
        phase = m_acc[k] + m_act[k];
        m_ce[k] = phase >= M;
        m_acc[k] = phase % M;
        m_sq[k] ^= m_ce[k];
        if (m_pend[k] && (m_ce[k] || m_act[k] == 0)) begin
          m_act[k] = m_stg[k];
          m_pend[k] = 0;
        end
      end else m_ce[k] = 0;
    end
    if (take) begin
      m_stg[c] = i;
      m_pend[c] = 1;
    end
    if (!m_lock) begin
      m_lock = m_cnt == 15;
      m_cnt++;
    end
  endtask
  task automatic step(input bit r, input bit vv = 0, input int c = 0, input logic [23:0] i = '0);
    exp_t e;
    rst = r;
    v = vv;
    ch = c[1:0];
    inc = i;
    if (m_ok) begin
      e.ce = m_ce;
      e.pend = m_pend;
      e.sq = m_sq;
      e.lock = m_lock;
      e.ready = m_ready(c);
      sb.push_back(e);
    end
    m_edge(r, vv, c, longint'(i));
    @(posedge clk);
    #1;
  endtask
  task automatic startup_check(input string tag);
    int lk, first, second;
    lk = 0;
    first = 0;
    second = 0;
    chk({tag, "_reset_ce"}, ce, 0);
    chk({tag, "_reset_pend"}, pend, 0);
    chk({tag, "_reset_lock"}, locked, 0);
`ifdef RELOJES_SQ_OUT_EN
    chk({tag, "_reset_sq"}, sq, 0);
`endif
    for (int k = 1; k <= 40; k++) begin
      step(0);
      if (locked === 1'b1 && lk == 0) lk = k;
      if (ce[0] === 1'b1) begin
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
    end
    chk({tag, "_lock_cycle"}, lk, 16);
    chk({tag, "_first_ce_delay"}, first - lk, 8);
    chk({tag, "_ce_period"}, second - first, 8);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_ce", ce, e.ce);
        chk("sb_pending", pend, e.pend);
        chk("sb_locked", locked, e.lock);
        chk("sb_ready", ready, e.ready);
`ifdef RELOJES_SQ_OUT_EN
        chk("sb_sq", sq, e.sq);
`endif
      end
    end
  end
  initial begin
    int t1[$], t0[$];
    int n_ce, wide, nz;
    bit prev;
    m_ok = 0;
    step(1);
    step(1);
    startup_check("boot");
    for (int k = 0; k < 3; k++) step(0);
    step(0, 1, 1, INC_7M);
    chk("ch1_pending_set", pend[1], 1);
    chk("ch1_ready_low", ready, 0);
    for (int k = 0; k < 30; k++) begin
      step(0);
      if (ce[1] === 1'b1) t1.push_back(k);
      if (ce[0] === 1'b1) t0.push_back(k);
    end
    chk("ch1_pulses_seen", t1.size() >= 3, 1);
    chk("ch1_first_gap", t1[1] - t1[0], 4);
    chk("ch1_second_gap", t1[2] - t1[1], 4);
    chk("ch0_undisturbed_gap", t0[1] - t0[0], 8);
    chk("ch1_pending_clear", pend[1], 0);
    step(0, 1, 0, 24'h155555);
    for (int k = 0; k < 20 && pend[0] === 1'b1; k++) step(0);
    chk("ch0_apply_done", pend[0], 0);
    n_ce = 0;
    wide = 0;
    prev = 0;
    for (int k = 0; k < 12000; k++) begin
      step(0);
      if (ce[0] === 1'b1) begin
        n_ce++;
        if (prev) wide++;
      end
      prev = ce[0] === 1'b1;
    end
    chk("ch0_rate_1000", n_ce >= 999 && n_ce <= 1001, 1);
    chk("ch0_single_width", wide, 0);
    step(0, 1, 2, INC_OFF);
    for (int k = 0; k < 20 && pend[2] === 1'b1; k++) step(0);
    chk("ch2_off_applied", pend[2], 0);
    nz = 0;
    for (int k = 0; k < 20; k++) begin
      step(0);
      if (ce[2] === 1'b1) nz++;
    end
    chk("ch2_off_silent", nz, 0);
    step(0, 1, 2, INC_14M);
    chk("ch2_14m_pending", pend[2], 1);
    step(0);
    chk("ch2_14m_next_cycle", pend[2], 0);
    nz = 0;
    for (int k = 0; k < 20; k++) begin
      step(0);
      if (ce[2] === 1'b1) nz++;
    end
    chk("ch2_14m_count", nz, 10);
    step(0, 1, 3, INC_7M);
    chk("ch3_pending_set", pend[3], 1);
    step(0);
    step(1);
    startup_check("rerun");
    for (int k = 0; k < 3000; k++) begin
      int sel;
      logic [23:0] ri;
      sel = $urandom_range(0, 5);
      ri = sel == 0 ? INC_3M5 : sel == 1 ? INC_7M : sel == 2 ? INC_14M :
           sel == 3 ? INC_OFF : sel == 4 ? 24'hFFFFFF : 24'($urandom_range(1, 24'h3FFFFF));
      step($urandom_range(0, 999) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3), ri);
    end
    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
